mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
//  Downstream of the 18-bit address register. Takes the register's address, a write byte and
//  a read/write request from the control unit, and runs one handshaked access to the image RAM.
//  Reports busy/done/err and holds read data for the accumulator/data path.
//  Sampled on posedge clk. The address register updates on negedge, so addr_in is stable here.
// PARAMETERS
//  ADDR_W    18      address width (matches address register output)
//  DATA_W    8       RAM data width
//  RD_LAT    2       RAM read latency in cycles from mem_en to valid mem_rdata (1..7)
//  IMG_SIZE  65536   number of valid pixel addresses; addr_in >= IMG_SIZE is out of bounds
// PORTS
//  clk        in   1       system clock, posedge
//  rst        in   1       asynchronous reset, active-high
//  addr_in    in   ADDR_W  address from address register
//  wdata_in   in   DATA_W  byte to write
//  rd_req     in   1       read request, sampled in IDLE only
//  wr_req     in   1       write request, sampled in IDLE only
//  busy       out  1       high in every state except IDLE
//  done       out  1       1-cycle pulse when an access completes or is rejected
//  err        out  1       1-cycle pulse with done when the address was out of bounds
//  rdata_out  out  DATA_W  last successfully read byte; held until the next successful read
//  mem_addr   out  ADDR_W  RAM address (latched copy of addr_in)
//  mem_wdata  out  DATA_W  RAM write data (latched copy of wdata_in)
//  mem_en     out  1       RAM enable
//  mem_we     out  1       RAM write enable
//  mem_rdata  in   DATA_W  RAM read data
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE. busy, done, err, mem_en, mem_we = 0.
//   rdata_out, mem_addr, mem_wdata = 0. Wait counter = 0.
//  FSM states: IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, FINISH.
//  IDLE, at the edge where a request is sampled:
//   - latch addr_in into mem_addr and wdata_in into mem_wdata.
//   - addr_in >= IMG_SIZE -> FINISH with the error flag set; no RAM cycle.
//   - else wr_req -> WR_ISSUE. Write wins if wr_req and rd_req are both high.
//   - else rd_req -> RD_ISSUE.
//  RD_ISSUE: mem_en=1, mem_we=0 for exactly one cycle. Counter loads RD_LAT-1.
//   Goes to RD_WAIT, or straight to capture if RD_LAT=1.
//  RD_WAIT: mem_en=0. Counter decrements each cycle.
//   At the edge where counter = 0: rdata_out <= mem_rdata, then go to FINISH.
//  WR_ISSUE: mem_en=1, mem_we=1 for exactly one cycle, then FINISH.
//  FINISH: done=1 for one cycle; err=1 if rejected; then IDLE.
//  Latency, counting from the request-sampling edge E:
//   - read: rdata_out valid and done high in the cycle after edge E+RD_LAT+1.
//   - write: done high in the cycle after edge E+2.
//   - OOB: done and err high in the cycle after edge E+1.
//  Requests while busy=1 are ignored (not queued). Requests must be re-asserted after done.
//  A request may be held high continuously: each IDLE visit starts a new access.
//  Boundaries:
//   - addr IMG_SIZE-1 is legal; IMG_SIZE is rejected.
//   - addr bits above log2(IMG_SIZE) are covered by the compare.
//   - mem_addr and mem_wdata stay stable from issue until the next accepted request.
//   - reset mid-access aborts it: mem_en/mem_we drop at once, no done pulse.
// CONFIGURATION
//  AUTO_INC_EN defined:
//   - adds output addr_next [ADDR_W-1:0], reset 0.
//   - at each successful (non-err) done, addr_next <= mem_addr+1, wrapping IMG_SIZE-1 -> 0.
//   - it is unchanged on err.
//   - the control unit uses it to reload the address register for raster scans.
//  AUTO_INC_EN undefined: port and logic absent. All other behaviour is identical.
// TESTING
//  1 Reset: assert rst mid-read (in RD_WAIT) -> busy, mem_en, done = 0 immediately;
//    IDLE after release; no done pulse.
//  2 Write: addr_in=18'h00123, wdata_in=8'hA5, wr_req 1 cycle -> one cycle of mem_en=mem_we=1
//    at mem_addr=0x00123; done pulses 2 cycles later; err=0.
//  3 Read, RD_LAT=2: RAM model holds 8'h3C at 0x00123, rd_req -> mem_en for 1 cycle;
//    rdata_out=8'h3C with done 3 cycles after sampling.
//  4 Simultaneous rd_req+wr_req -> a write is performed (mem_we=1); rdata_out unchanged.
//  5 OOB: addr_in=65536 (IMG_SIZE default), rd_req -> mem_en never asserts;
//    done=err=1 next cycle; rdata_out unchanged. Then addr 65535 succeeds with err=0.
//  6 AUTO_INC_EN: read at 65535 -> addr_next=0; write at 0x00010 -> addr_next=0x00011;
//    a request during busy is ignored (one done only).

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Single-access handshake controller between the address register and the image RAM.
// Optional AUTO_INC_EN adds addr_next, the post-access address for raster scans.
module mem_access_ctrl #(
  parameter int ADDR_W   = 18,
  parameter int DATA_W   = 8,
  parameter int RD_LAT   = 2,
  parameter int IMG_SIZE = 65536
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] wdata_in,
  input  logic              rd_req,
  input  logic              wr_req,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] rdata_out,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_en,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef AUTO_INC_EN
  ,
  output logic [ADDR_W-1:0] addr_next
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_WAIT,
    WR_ISSUE,
    FINISH
  } state_t;

  localparam logic [ADDR_W:0]   LIMIT  = (ADDR_W+1)'(IMG_SIZE);
  localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(IMG_SIZE - 1);
  localparam logic [2:0]        LAT_M1 = 3'(RD_LAT - 1);

  state_t     state;
  logic [2:0] cnt;
  logic       rejected;
  logic       oob;

  // Extra top bit keeps the compare exact for every address bit pattern.
  assign oob = ({1'b0, addr_in} >= LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      rejected  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      rdata_out <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
`ifdef AUTO_INC_EN
      addr_next <= '0;
`endif
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (rd_req || wr_req) begin
            mem_addr  <= addr_in;
            mem_wdata <= wdata_in;
            busy      <= 1'b1;
            rejected  <= oob;
            if (oob) begin
              state <= FINISH;
            end else if (wr_req) begin
              state  <= WR_ISSUE;
              mem_en <= 1'b1;
              mem_we <= 1'b1;
            end else begin
              state  <= RD_ISSUE;
              mem_en <= 1'b1;
              cnt    <= LAT_M1;
            end
          end
        end
        RD_ISSUE, RD_WAIT: begin
          mem_en <= 1'b0;
          if (cnt == 3'd0) begin
            rdata_out <= mem_rdata;
            state     <= FINISH;
          end else begin
            cnt   <= cnt - 3'd1;
            state <= RD_WAIT;
          end
        end
        WR_ISSUE: begin
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          state  <= FINISH;
        end
        FINISH: begin
          done  <= 1'b1;
          err   <= rejected;
          busy  <= 1'b0;
          state <= IDLE;
`ifdef AUTO_INC_EN
          if (!rejected)
            addr_next <= (mem_addr == LAST) ? '0 : mem_addr + 1'b1;
`endif
        end
        default: begin
          state  <= IDLE;
          busy   <= 1'b0;
          mem_en <= 1'b0;
          mem_we <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a two-cycle registered RAM model.
// Define AUTO_INC_EN to exercise addr_next as well.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [17:0] addr_in;
  logic [7:0]  wdata_in;
  logic        rd_req;
  logic        wr_req;
  logic        busy;
  logic        done;
  logic        err;
  logic [7:0]  rdata_out;
  logic [17:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_en;
  logic        mem_we;
  logic [7:0]  mem_rdata = 8'hEE;
`ifdef AUTO_INC_EN
  logic [17:0] addr_next;
`endif

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int en_cnt = 0;
  int we_cnt = 0;
  logic [17:0] last_wa = '0;
  logic [7:0]  last_wd = '0;
  logic [7:0]  ram [0:65535];
  int d0, e0, w0;

  mem_access_ctrl dut (
    .clk(clk), .rst(rst), .addr_in(addr_in), .wdata_in(wdata_in),
    .rd_req(rd_req), .wr_req(wr_req), .busy(busy), .done(done),
    .err(err), .rdata_out(rdata_out), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_en(mem_en), .mem_we(mem_we),
    .mem_rdata(mem_rdata)
`ifdef AUTO_INC_EN
    , .addr_next(addr_next)
`endif
  );

  always #5 clk = ~clk;

  // Read data is valid for exactly one cycle, so mistimed captures show up.
  always @(posedge clk) begin
    mem_rdata <= (mem_en && !mem_we) ? ram[mem_addr[15:0]] : 8'hEE;
    if (mem_en) en_cnt <= en_cnt + 1;
    if (mem_en && mem_we) begin
      we_cnt  <= we_cnt + 1;
      last_wa <= mem_addr;
      last_wd <= mem_wdata;
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    ram[16'h0123] = 8'h3C;
    ram[16'hFFFF] = 8'h77;
    ram[16'h0010] = 8'h11;
    rst = 1'b1; addr_in = '0; wdata_in = '0; rd_req = 0; wr_req = 0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_en", mem_en, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_rdata", rdata_out, 0);
    chk("rst_maddr", mem_addr, 0);
    chk("rst_mwdata", mem_wdata, 0);
`ifdef AUTO_INC_EN
    chk("rst_anext", addr_next, 0);
`endif
    rst = 1'b0;

    // reset in the middle of a read
    @(negedge clk); addr_in = 18'h00123; rd_req = 1;
    @(negedge clk); rd_req = 0;
    chk("mid_en_before", mem_en, 1);
    @(negedge clk);
    chk("mid_busy_before", busy, 1);
    d0 = done_cnt;
    rst = 1'b1;
    #1;
    chk("mid_busy", busy, 0);
    chk("mid_en", mem_en, 0);
    chk("mid_done", done, 0);
    @(negedge clk); rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_no_done", done_cnt, d0);
    chk("mid_idle", busy, 0);
    chk("mid_rdata", rdata_out, 0);

    // write
    addr_in = 18'h00123; wdata_in = 8'hA5; wr_req = 1;
    @(negedge clk); wr_req = 0;
    chk("wr_en", mem_en, 1);
    chk("wr_we", mem_we, 1);
    chk("wr_addr", mem_addr, 18'h00123);
    chk("wr_wdata", mem_wdata, 8'hA5);
    chk("wr_busy", busy, 1);
    @(negedge clk);
    chk("wr_en_off", mem_en, 0);
    chk("wr_done_early", done, 0);
    @(negedge clk);
    chk("wr_done", done, 1);
    chk("wr_err", err, 0);
    chk("wr_busy_off", busy, 0);
    chk("wr_ram_addr", last_wa, 18'h00123);
    chk("wr_ram_data", last_wd, 8'hA5);
`ifdef AUTO_INC_EN
    chk("wr_anext", addr_next, 18'h00124);
`endif
    @(negedge clk);
    chk("wr_done_pulse", done, 0);

    // read 0x123 -> 3C
    e0 = en_cnt;
    addr_in = 18'h00123; rd_req = 1;
    @(negedge clk); rd_req = 0;
    chk("rd_en", mem_en, 1);
    chk("rd_we", mem_we, 0);
    @(negedge clk);
    chk("rd_en_off", mem_en, 0);
    @(negedge clk);
    chk("rd_done_early", done, 0);
    @(negedge clk);
    chk("rd_done", done, 1);
    chk("rd_err", err, 0);
    chk("rd_data", rdata_out, 8'h3C);
    chk("rd_en_once", en_cnt - e0, 1);
    @(negedge clk);
    chk("rd_hold", rdata_out, 8'h3C);

    // simultaneous request: write wins
    w0 = we_cnt;
    addr_in = 18'h00200; wdata_in = 8'h5A; rd_req = 1; wr_req = 1;
    @(negedge clk); rd_req = 0; wr_req = 0;
    chk("both_we", mem_we, 1);
    repeat (2) @(negedge clk);
    chk("both_done", done, 1);
    chk("both_wcnt", we_cnt - w0, 1);
    chk("both_wd", last_wd, 8'h5A);
    chk("both_rdata", rdata_out, 8'h3C);

    // out of bounds: exactly IMG_SIZE
    @(negedge clk);
    e0 = en_cnt;
    addr_in = 18'h10000; rd_req = 1;
    @(negedge clk); rd_req = 0;
    chk("oob_en", mem_en, 0);
    chk("oob_busy", busy, 1);
    @(negedge clk);
    chk("oob_done", done, 1);
    chk("oob_err", err, 1);
    chk("oob_rdata", rdata_out, 8'h3C);
    chk("oob_no_en", en_cnt - e0, 0);
`ifdef AUTO_INC_EN
    chk("oob_anext", addr_next, 18'h00201);
`endif
    @(negedge clk);
    chk("oob_err_pulse", err, 0);

    // upper address bit alone is rejected
    addr_in = 18'h20005; wr_req = 1;
    @(negedge clk); wr_req = 0;
    chk("oob_hi_we", mem_we, 0);
    @(negedge clk);
    chk("oob_hi_err", err, 1);

    // last legal address
    @(negedge clk);
    addr_in = 18'h0FFFF; rd_req = 1;
    @(negedge clk); rd_req = 0;
    chk("last_en", mem_en, 1);
    repeat (3) @(negedge clk);
    chk("last_done", done, 1);
    chk("last_err", err, 0);
    chk("last_rdata", rdata_out, 8'h77);
`ifdef AUTO_INC_EN
    chk("last_anext", addr_next, 18'h00000);
`endif

    // requests while busy are dropped
    @(negedge clk);
    d0 = done_cnt; w0 = we_cnt;
    addr_in = 18'h00010; rd_req = 1;
    @(negedge clk); rd_req = 0;
    addr_in = 18'h00300; wr_req = 1;
    repeat (2) @(negedge clk);
    wr_req = 0;
    @(negedge clk);
    chk("busy_done", done, 1);
    chk("busy_rdata", rdata_out, 8'h11);
    chk("busy_maddr", mem_addr, 18'h00010);
`ifdef AUTO_INC_EN
    chk("busy_anext", addr_next, 18'h00011);
`endif
    repeat (3) @(negedge clk);
    chk("busy_one_done", done_cnt - d0, 1);
    chk("busy_no_wr", we_cnt - w0, 0);

    // held request restarts on each IDLE visit
    d0 = done_cnt; w0 = we_cnt;
    addr_in = 18'h00040; wdata_in = 8'h99; wr_req = 1;
    repeat (4) @(negedge clk);
    wr_req = 0;
    repeat (4) @(negedge clk);
    chk("held_writes", we_cnt - w0, 2);
    chk("held_dones", done_cnt - d0, 2);
    chk("held_maddr", mem_addr, 18'h00040);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
